// File: rtl/sign_mag_pkg.sv
// Shared definitions for the sign-magnitude arbiter: FSM state encoding and
// the largest representable magnitude for a given operand width.
package sign_mag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int max_mag(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

endpackage

// File: rtl/sign_mag_add.sv
// Combinational sign-magnitude adder (MSB = sign). Magnitude wraps on overflow;
// a zero-magnitude result may carry either sign, so callers normalise it.
module sign_mag_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);
    localparam int M = N - 1;

    logic [M-1:0] mag_a;
    logic [M-1:0] mag_b;
    logic [M-1:0] mag_sum;
    logic         sign_a;
    logic         sign_b;
    logic         sign_sum;

    assign sign_a = a[N-1];
    assign sign_b = b[N-1];
    assign mag_a  = a[M-1:0];
    assign mag_b  = b[M-1:0];

    // Unlike signs: subtract the smaller magnitude and keep the larger one's sign.
    always_comb begin
        mag_sum  = '0;
        sign_sum = 1'b0;
        if (sign_a == sign_b) begin
            mag_sum  = mag_a + mag_b;
            sign_sum = sign_a;
        end else if (mag_a >= mag_b) begin
            mag_sum  = mag_a - mag_b;
            sign_sum = sign_a;
        end else begin
            mag_sum  = mag_b - mag_a;
            sign_sum = sign_b;
        end
    end

    assign sum = {sign_sum, mag_sum};

endmodule

// File: rtl/sign_mag_arb.sv
// Two-requester round-robin front end sharing one sign-magnitude adder.
// Define SIGN_MAG_OVF_EN to generate the magnitude-overflow flag on rsp_ovf.
module sign_mag_arb
    import sign_mag_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_id,
    output logic         rsp_ovf
);
    state_t       state_reg;
    logic         last_grant_reg;
    logic [N-1:0] op_a_reg;
    logic [N-1:0] op_b_reg;
    logic         op_id_reg;
    logic         rsp_valid_reg;
    logic [N-1:0] rsp_sum_reg;
    logic         rsp_id_reg;

    logic [1:0]   req_valid;
    logic [N-1:0] req_a [2];
    logic [N-1:0] req_b [2];
    logic [1:0]   req_ready;
    logic         grant_valid;
    logic         grant_id;
    logic [N-1:0] add_sum;
    logic [N-1:0] norm_sum;

    assign req_valid = {req1_valid, req0_valid};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    // Readys are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (reset_n && state_reg == IDLE) begin
            if (req_valid == 2'b11) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_reg;
            end else if (req_valid[0]) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req_valid[1]) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    sign_mag_add #(
        .N(N)
    ) u_add (
        .a   (op_a_reg),
        .b   (op_b_reg),
        .sum (add_sum)
    );

    // A zero magnitude is always presented as +0.
    assign norm_sum = (add_sum[N-2:0] == '0) ? '0 : add_sum;

`ifdef SIGN_MAG_OVF_EN
    localparam logic [N-1:0] MAX_MAG = N'(max_mag(N));
    logic [N-1:0] mag_total;
    logic         ovf_calc;
    logic         rsp_ovf_reg;

    assign mag_total = {1'b0, op_a_reg[N-2:0]} + {1'b0, op_b_reg[N-2:0]};
    assign ovf_calc  = (op_a_reg[N-1] == op_b_reg[N-1]) && (mag_total > MAX_MAG);
    assign rsp_ovf   = rsp_ovf_reg;
`else
    assign rsp_ovf   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_id_reg      <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_sum_reg    <= '0;
            rsp_id_reg     <= 1'b0;
`ifdef SIGN_MAG_OVF_EN
            rsp_ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        op_a_reg       <= req_a[grant_id];
                        op_b_reg       <= req_b[grant_id];
                        op_id_reg      <= grant_id;
                        last_grant_reg <= grant_id;
                        state_reg      <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_reg <= norm_sum;
                    rsp_id_reg  <= op_id_reg;
`ifdef SIGN_MAG_OVF_EN
                    rsp_ovf_reg <= ovf_calc;
`endif
                    state_reg   <= RESP;
                end
                RESP: begin
                    // First RESP cycle raises valid; the result is then held until taken.
                    if (!rsp_valid_reg) begin
                        rsp_valid_reg <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_sign_mag_arb.sv
// Self-checking bench for sign_mag_arb: directed scenarios then random traffic,
// compared against a transaction-level arithmetic model.
module tb_sign_mag_arb;
    localparam int N    = 4;
    localparam int MAXM = (1 << (N - 1)) - 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic         req1_valid = 1'b0;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic         rsp_ready = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic         rsp_valid;
    logic [N-1:0] rsp_sum;
    logic         rsp_id;
    logic         rsp_ovf;

    always #5 clk = ~clk;

    sign_mag_arb #(
        .N(N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id),
        .rsp_ovf    (rsp_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: busy from accept until the response handshake.
    bit           m_busy  = 1'b0;
    bit           m_fresh = 1'b1;
    bit           m_lg    = 1'b1;
    int           m_age   = 0;
    logic [N-1:0] m_sum   = '0;
    bit           m_id    = 1'b0;
    bit           m_ovf   = 1'b0;

    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
        int ma, mb, va, vb, m;
        bit s, ovf;
        ma = int'(a[N-2:0]);
        mb = int'(b[N-2:0]);
        va = a[N-1] ? -ma : ma;
        vb = b[N-1] ? -mb : mb;
        if (a[N-1] == b[N-1]) begin
            m   = (ma + mb) % (MAXM + 1);
            s   = a[N-1];
            ovf = (ma + mb) > MAXM;
        end else begin
            m   = va + vb;
            s   = (m < 0);
            if (m < 0) m = -m;
            ovf = 1'b0;
        end
        if (m == 0) s = 1'b0;
`ifndef SIGN_MAG_OVF_EN
        ovf = 1'b0;
`endif
        return {ovf, s, m[N-2:0]};
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_val({tag, ".rsp_sum"}, 32'(rsp_sum), 32'd0);
        check_val({tag, ".rsp_id"}, 32'(rsp_id), 32'd0);
        check_val({tag, ".rsp_ovf"}, 32'(rsp_ovf), 32'd0);
        check_val({tag, ".req0_ready"}, 32'(req0_ready), 32'd0);
        check_val({tag, ".req1_ready"}, 32'(req1_ready), 32'd0);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic run_cycle(input string tag);
        bit         exp_valid, g_valid, g_id;
        logic [N:0] r;
        #1;
        exp_valid = m_busy && (m_age >= 2);
        check_val({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_val({tag, ".rsp_sum"}, 32'(rsp_sum), 32'(m_sum));
            check_val({tag, ".rsp_id"}, 32'(rsp_id), 32'(m_id));
            check_val({tag, ".rsp_ovf"}, 32'(rsp_ovf), 32'(m_ovf));
        end else if (m_fresh) begin
            check_val({tag, ".rsp_sum0"}, 32'(rsp_sum), 32'd0);
            check_val({tag, ".rsp_ovf0"}, 32'(rsp_ovf), 32'd0);
        end
        g_valid = 1'b0;
        g_id    = 1'b0;
        if (!m_busy) begin
            if (req0_valid && req1_valid) begin
                g_valid = 1'b1;
                g_id    = !m_lg;
            end else if (req0_valid) begin
                g_valid = 1'b1;
            end else if (req1_valid) begin
                g_valid = 1'b1;
                g_id    = 1'b1;
            end
        end
        check_val({tag, ".req0_ready"}, 32'(req0_ready), 32'(g_valid && !g_id));
        check_val({tag, ".req1_ready"}, 32'(req1_ready), 32'(g_valid && g_id));
        @(posedge clk);
        if (g_valid) begin
            r       = g_id ? ref_add(req1_a, req1_b) : ref_add(req0_a, req0_b);
            m_sum   = r[N-1:0];
            m_ovf   = r[N];
            m_id    = g_id;
            m_lg    = g_id;
            m_busy  = 1'b1;
            m_age   = 0;
            m_fresh = 1'b0;
        end else if (m_busy) begin
            if (exp_valid && rsp_ready) begin
                m_busy = 1'b0;
                $display("%s: rsp id=%0d sum=%b ovf=%0d", tag, m_id, m_sum, m_ovf);
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset (optionally checking the asynchronous clear at once), holds it, releases at a negedge.
    task automatic do_reset(input string tag, input bit check_now, input int cycles);
        reset_n = 1'b0;
        m_busy  = 1'b0;
        m_lg    = 1'b1;
        m_age   = 0;
        m_fresh = 1'b1;
        if (check_now) begin
            #1;
            check_all_zero({tag, ".async"});
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_all_zero(tag);
            @(negedge clk);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        do_reset("reset", 1'b0, 2);

        // Single operation from requester 0.
        req1_valid = 1'b0;
        req0_a = 4'b0100; req0_b = 4'b0001; rsp_ready = 1'b1;
        run_cycle("single");
        req0_valid = 1'b0;
        repeat (5) run_cycle("single");

        // Both requesters continuously valid: grants alternate.
        req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b0010;
        req1_valid = 1'b1; req1_a = 4'b1001; req1_b = 4'b1010;
        repeat (16) run_cycle("rr");
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) run_cycle("rr");

        // Magnitude overflow wraps.
        req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b0010;
        run_cycle("ovf");
        req0_valid = 1'b0;
        repeat (5) run_cycle("ovf");

        // Equal and opposite operands give +0.
        req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b1010;
        run_cycle("zero");
        req1_valid = 1'b0;
        repeat (5) run_cycle("zero");

        // Back-pressure with a pending requester.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b1011; req0_b = 4'b1001;
        run_cycle("stall");
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b0011; req1_b = 4'b0101;
        repeat (7) run_cycle("stall");
        rsp_ready = 1'b1;
        run_cycle("stall");
        req1_valid = 1'b0;
        repeat (6) run_cycle("stall");

        // Reset while the operation is in CALC.
        req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0001;
        run_cycle("midrst");
        req1_valid = 1'b1;
        do_reset("midrst", 1'b1, 2);
        req0_a = 4'b0001; req0_b = 4'b0001;
        req1_a = 4'b1110; req1_b = 4'b0001;
        run_cycle("midrst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) run_cycle("midrst");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a     = N'($urandom);
            req0_b     = N'($urandom);
            req1_a     = N'($urandom);
            req1_b     = N'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            run_cycle("rand");
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) run_cycle("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
